// File: rtl/wb_counter_bank_if.sv
// Wishbone slave bundle for the counter bank; the bench or user-project
// wrapper drives the master side.
interface wb_counter_bank_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_counter_bank.sv
// Multi-channel up/down counter/timer bank behind a Wishbone slave port.
// Each channel has CTRL/COUNT/CMP/STATUS; sticky match can raise irq_o.
module wb_counter_bank_chan #(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [1:0]      reg_sel,
  input  logic [3:0]      sel,
  input  logic [31:0]     wdat,
  output logic [BITS-1:0] count_o,
  output logic [31:0]     rdat_o,
  output logic            irq_o
);
  logic [3:0]      ctrl_q, ctrl_d;
  logic [BITS-1:0] count_q, count_d, cmp_q, cmp_d, count_nxt;
  logic            match_q, match_d, hit;

  // Byte-lane merge on a zero-extended 32-bit view; lanes above BITS fall off.
  function automatic logic [BITS-1:0] lane_merge(input logic [BITS-1:0] old_v,
                                                 input logic [31:0] new_v,
                                                 input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    m[BITS-1:0] = old_v;
    for (int b = 0; b < 4; b++)
      if (be[b]) m[8*b +: 8] = new_v[8*b +: 8];
    return m[BITS-1:0];
  endfunction

  always_comb begin
    hit       = ctrl_q[1] ? (count_q == '0) : (count_q == cmp_q);
    count_nxt = count_q;
    if (ctrl_q[0]) begin
      if (ctrl_q[1]) count_nxt = (hit && ctrl_q[2]) ? cmp_q : count_q - BITS'(1);
      else           count_nxt = (hit && ctrl_q[2]) ? '0    : count_q + BITS'(1);
    end
    ctrl_d  = ctrl_q;
    count_d = count_nxt;
    cmp_d   = cmp_q;
    match_d = match_q;
    if (wr_en) begin
      case (reg_sel)
        2'd0:    if (sel[0]) ctrl_d = wdat[3:0];
        2'd1:    count_d = lane_merge(count_nxt, wdat, sel);
        2'd2:    cmp_d   = lane_merge(cmp_q, wdat, sel);
        default: if (sel[0] && wdat[0]) match_d = 1'b0;
      endcase
    end
    // a fresh match outranks a same-cycle W1C
    if (ctrl_q[0] && hit) match_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q  <= '0;
      count_q <= '0;
      cmp_q   <= '0;
      match_q <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
      match_q <= match_d;
    end
  end

  always_comb begin
    rdat_o = '0;
    case (reg_sel)
      2'd0:    rdat_o[3:0]      = ctrl_q;
      2'd1:    rdat_o[BITS-1:0] = count_q;
      2'd2:    rdat_o[BITS-1:0] = cmp_q;
      default: rdat_o[0]        = match_q;
    endcase
  end

  assign count_o = count_q;
  assign irq_o   = match_q & ctrl_q[3];
endmodule

module wb_counter_bank #(
  parameter int CHANNELS = 4,
  parameter int BITS     = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  wb_counter_bank_if.slave         wbs,
  output logic [CHANNELS*BITS-1:0] count_o,
  output logic                     irq_o
);
  logic                           accept, ack_q, ack_d;
  logic [31:0]                    dat_q, dat_d, rd_mux;
  logic [2:0]                     ch_sel;
  logic [1:0]                     reg_sel;
  logic [CHANNELS-1:0]            wr_ch, irq_ch;
  logic [CHANNELS-1:0][BITS-1:0]  cnt;
  logic [CHANNELS-1:0][31:0]      rdat;
  logic                           unused_adr;

  assign accept     = wbs.wbs_cyc_i && wbs.wbs_stb_i && !ack_q;
  assign ch_sel     = wbs.wbs_adr_i[6:4];
  assign reg_sel    = wbs.wbs_adr_i[3:2];
  assign unused_adr = ^{wbs.wbs_adr_i[31:7], wbs.wbs_adr_i[1:0]};

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign wr_ch[i] = accept && wbs.wbs_we_i && (ch_sel == 3'(i));
    wb_counter_bank_chan #(.BITS(BITS)) u_chan (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_ch[i]),
      .reg_sel (reg_sel),
      .sel     (wbs.wbs_sel_i),
      .wdat    (wbs.wbs_dat_i),
      .count_o (cnt[i]),
      .rdat_o  (rdat[i]),
      .irq_o   (irq_ch[i])
    );
  end

  // Channel indices with no channel behind them read as zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < CHANNELS; i++)
      if (ch_sel == 3'(i)) rd_mux = rdat[i];
    ack_d = accept;
    dat_d = (accept && !wbs.wbs_we_i) ? rd_mux : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= ack_d;
      dat_q <= dat_d;
    end
  end

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;
  assign count_o       = cnt;
  assign irq_o         = |irq_ch;
endmodule

// File: tb/tb_wb_counter_bank.sv
// Directed bench: a 32-bit and an 8-bit bank share one bus stimulus stream.
module tb_wb_counter_bank;
  logic        clk, reset;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic [127:0] cnt32;
  logic [31:0]  cnt8;
  logic         irq32, irq8;
  logic [31:0]  rd_v, rd8_v;
  int errors = 0;
  int checks = 0;

  wb_counter_bank_if bus32();
  wb_counter_bank_if bus8();
  assign bus32.wbs_cyc_i = cyc;  assign bus8.wbs_cyc_i = cyc;
  assign bus32.wbs_stb_i = stb;  assign bus8.wbs_stb_i = stb;
  assign bus32.wbs_we_i  = we;   assign bus8.wbs_we_i  = we;
  assign bus32.wbs_sel_i = sel;  assign bus8.wbs_sel_i = sel;
  assign bus32.wbs_adr_i = adr;  assign bus8.wbs_adr_i = adr;
  assign bus32.wbs_dat_i = wdat; assign bus8.wbs_dat_i = wdat;

  wb_counter_bank #(.CHANNELS(4), .BITS(32)) dut (
    .clk(clk), .reset(reset), .wbs(bus32.slave), .count_o(cnt32), .irq_o(irq32));
  wb_counter_bank #(.CHANNELS(4), .BITS(8)) dut8 (
    .clk(clk), .reset(reset), .wbs(bus8.slave), .count_o(cnt8), .irq_o(irq8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s);
    if (bus32.wbs_ack_o) @(negedge clk);
    cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s;
    @(negedge clk);
    chk("ack", bus32.wbs_ack_o, 1);
    rd_v = bus32.wbs_dat_o; rd8_v = bus8.wbs_dat_o;
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus(1'b1, a, d, 4'hF);
  endtask

  task automatic rd(input logic [31:0] a);
    bus(1'b0, a, 32'h0, 4'hF);
  endtask

  logic [31:0] up_seq [8] = '{0, 1, 2, 3, 4, 5, 0, 1};
  logic [7:0]  dn_seq [5] = '{8'h02, 8'h01, 8'h00, 8'hFF, 8'hFE};
  logic [7:0]  ar_seq [8] = '{2, 1, 0, 3, 2, 1, 0, 3};
  logic [31:0] vals   [4] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h1234_5678};
  int acks;
  logic [5:0] ack_pat;

  initial begin
    reset = 1; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; wdat = 0;
    repeat (2) @(negedge clk);
    reset = 0;

    // reset defaults
    chk("rst_ack", bus32.wbs_ack_o, 0);
    chk("rst_dat", bus32.wbs_dat_o, 0);
    chk("rst_cnt", cnt32, 0);
    chk("rst_cnt8", cnt8, 0);
    chk("rst_irq", irq32, 0);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        rd(32'(c*16 + r*4));
        chk("rst_rd", rd_v, 0);
      end

    // up mode with auto-reload on ch0
    wr(32'h08, 5);
    wr(32'h00, 32'hD);
    for (int i = 0; i < 8; i++) begin
      chk("up_cnt", cnt32[31:0], up_seq[i]);
      chk("up_irq", irq32, (i >= 6) ? 1'b1 : 1'b0);
      @(negedge clk);
    end
    rd(32'h0C);
    chk("up_status", rd_v, 1);
    wr(32'h0C, 1);
    chk("w1c_irq", irq32, 0);
    chk("w1c_cnt", cnt32[31:0], 5);
    @(negedge clk);
    chk("rewrap_irq", irq32, 1);
    chk("rewrap_cnt", cnt32[31:0], 0);
    wr(32'h00, 0);

    // down mode on ch1, checked on the 8-bit bank
    wr(32'h14, 2);
    wr(32'h10, 3);
    for (int i = 0; i < 5; i++) begin
      chk("dn_cnt8", cnt8[15:8], dn_seq[i]);
      if (i == 3) chk("dn_cnt32", cnt32[63:32], 32'hFFFF_FFFF);
      @(negedge clk);
    end
    rd(32'h1C);
    chk("dn_status", rd8_v, 1);
    wr(32'h10, 0);
    wr(32'h18, 3);
    wr(32'h14, 2);
    wr(32'h10, 7);
    for (int i = 0; i < 8; i++) begin
      chk("dn_ar_cnt8", cnt8[15:8], ar_seq[i]);
      @(negedge clk);
    end
    wr(32'h10, 0);

    // byte-lane write while ch2 counts up
    wr(32'h24, 32'hFE);
    wr(32'h20, 1);
    chk("bl_start", cnt32[95:64], 32'hFE);
    bus(1'b1, 32'h24, 32'hAABB_CCDD, 4'b0100);
    chk("bl_merge", cnt32[95:64], 32'h00BB_0100);
    chk("bl_merge8", cnt8[23:16], 8'h00);
    @(negedge clk);
    chk("bl_next", cnt32[95:64], 32'h00BB_0101);
    wr(32'h20, 0);

    // handshake: held read acks on alternate cycles
    if (bus32.wbs_ack_o) @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = 32'h00; sel = 4'hF;
    acks = 0; ack_pat = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      acks += int'(bus32.wbs_ack_o);
      ack_pat[5-i] = bus32.wbs_ack_o;
    end
    cyc = 0; stb = 0;
    chk("hold_acks", acks, 3);
    chk("hold_pat", ack_pat, 6'b101010);

    // decode: missing channels and bits above BITS
    for (int c = 0; c < 4; c++) wr(32'(c*16 + 4), vals[c]);
    rd(32'h74);
    chk("ch7_rd", rd_v, 0);
    rd(32'h34);
    chk("ch3_rd", rd_v, 32'h1234_5678);
    chk("ch3_rd8", rd8_v, 32'h78);
    wr(32'h74, 32'hDEAD_BEEF);
    wr(32'h70, 32'hF);
    wr(32'h78, 32'h0);
    wr(32'h30, 32'hFFFF_FFF0);
    rd(32'h30);
    chk("ctrl_hi0", rd_v, 0);
    repeat (3) @(negedge clk);
    chk("ch7_nochg", cnt32, {vals[3], vals[2], vals[1], vals[0]});
    chk("ch7_nochg8", cnt8, 32'h7833_2211);

    // W1C in the same cycle as a new match on ch0
    wr(32'h0C, 1);
    wr(32'h04, 0);
    wr(32'h08, 3);
    wr(32'h00, 32'h9);
    repeat (3) @(negedge clk);
    wr(32'h0C, 1);
    chk("sim_cnt", cnt32[31:0], 4);
    chk("sim_irq", irq32, 1);
    rd(32'h0C);
    chk("sim_status", rd_v, 1);

    // reset during a pending write
    if (bus32.wbs_ack_o) @(negedge clk);
    cyc = 1; stb = 1; we = 1; adr = 32'h14; wdat = 32'h55; sel = 4'hF;
    reset = 1;
    @(negedge clk);
    chk("rstx_ack", bus32.wbs_ack_o, 0);
    cyc = 0; stb = 0; we = 0;
    @(negedge clk);
    reset = 0;
    chk("rstx_cnt", cnt32, 0);
    chk("rstx_cnt8", cnt8, 0);
    chk("rstx_irq", irq32, 0);
    rd(32'h00);
    chk("rstx_ctrl", rd_v, 0);
    rd(32'h0C);
    chk("rstx_status", rd_v, 0);
    rd(32'h18);
    chk("rstx_cmp", rd_v, 0);
    repeat (3) @(negedge clk);
    chk("rstx_hold", cnt32, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
